// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: two-stage pipelined target/condition evaluation with a
// valid/ready handshake on both sides and saturating delivery statistics.
module branch_resolve_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned OFF_W = 16,
    parameter int unsigned SHIFT = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // request side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [OFF_W-1:0] in_offset,
    input  logic [2:0]       in_cond,
    // result side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_next_pc,
    output logic             out_taken,
    output logic             out_zero,
    output logic             out_misaligned,
    // statistics
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] resolved_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [2:0] {
        CondEq     = 3'b000,
        CondNe     = 3'b001,
        CondAlways = 3'b010,
        CondNever  = 3'b011,
        CondLt     = 3'b100,
        CondGe     = 3'b101,
        CondLtu    = 3'b110,
        CondGeu    = 3'b111
    } cond_e;

    localparam logic [XLEN-1:0]  InstrBytes = XLEN'(1) << SHIFT;
    localparam logic [XLEN-1:0]  AlignMask  = InstrBytes - XLEN'(1);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax     = '1;

    // Request-side arithmetic
    logic [XLEN-1:0] off_ext;
    logic [XLEN-1:0] req_target;
    logic [XLEN-1:0] req_fall;
    logic            req_eq;
    logic            req_lt_s;
    logic            req_lt_u;

    // Stage 1 state
    logic            s1_valid_q, s1_valid_d;
    logic [XLEN-1:0] s1_pc_q, s1_pc_d;
    logic [XLEN-1:0] s1_target_q, s1_target_d;
    logic [XLEN-1:0] s1_fall_q, s1_fall_d;
    logic            s1_eq_q, s1_eq_d;
    logic            s1_lt_s_q, s1_lt_s_d;
    logic            s1_lt_u_q, s1_lt_u_d;
    cond_e           s1_cond_q, s1_cond_d;

    // Stage 1 decode feeding stage 2
    logic            s1_taken;
    logic [XLEN-1:0] s1_next_pc;
    logic            s1_misaligned;

    // Stage 2 state (drives the outputs directly)
    logic            s2_valid_q, s2_valid_d;
    logic [XLEN-1:0] s2_pc_q, s2_pc_d;
    logic [XLEN-1:0] s2_target_q, s2_target_d;
    logic [XLEN-1:0] s2_next_pc_q, s2_next_pc_d;
    logic            s2_taken_q, s2_taken_d;
    logic            s2_zero_q, s2_zero_d;
    logic            s2_mis_q, s2_mis_d;

    // Statistics
    logic [CNT_W-1:0] resolved_q, resolved_d;
    logic [CNT_W-1:0] taken_q, taken_d;

    // Handshake control
    logic in_hs;
    logic out_hs;
    logic s2_load;

    // Target, fall-through and raw compare flags from the incoming request
    always_comb begin
        off_ext    = {{(XLEN-OFF_W){in_offset[OFF_W-1]}}, in_offset};
        req_target = in_pc + (off_ext << SHIFT);
        req_fall   = in_pc + InstrBytes;
        req_eq     = (in_a == in_b);
        req_lt_s   = ($signed(in_a) < $signed(in_b));
        req_lt_u   = (in_a < in_b);
    end

    // Flow control: S2 frees when empty or popped; S1 may then refill the same cycle
    always_comb begin
        out_hs   = s2_valid_q && out_ready;
        s2_load  = !s2_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_load;
        in_hs    = in_valid && in_ready;
    end

    // Stage 1 next state: capture on accept, drain when S2 takes the entry
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_pc_d     = s1_pc_q;
        s1_target_d = s1_target_q;
        s1_fall_d   = s1_fall_q;
        s1_eq_d     = s1_eq_q;
        s1_lt_s_d   = s1_lt_s_q;
        s1_lt_u_d   = s1_lt_u_q;
        s1_cond_d   = s1_cond_q;
        if (s2_load) begin
            s1_valid_d = 1'b0;
        end
        if (in_hs) begin
            s1_valid_d  = 1'b1;
            s1_pc_d     = in_pc;
            s1_target_d = req_target;
            s1_fall_d   = req_fall;
            s1_eq_d     = req_eq;
            s1_lt_s_d   = req_lt_s;
            s1_lt_u_d   = req_lt_u;
            s1_cond_d   = cond_e'(in_cond);
        end
    end

    // Condition evaluation and next-PC selection on the S1 contents
    always_comb begin
        s1_taken = 1'b0;
        unique case (s1_cond_q)
            CondEq:     s1_taken = s1_eq_q;
            CondNe:     s1_taken = !s1_eq_q;
            CondAlways: s1_taken = 1'b1;
            CondNever:  s1_taken = 1'b0;
            CondLt:     s1_taken = s1_lt_s_q;
            CondGe:     s1_taken = !s1_lt_s_q;
            CondLtu:    s1_taken = s1_lt_u_q;
            CondGeu:    s1_taken = !s1_lt_u_q;
            default:    s1_taken = 1'b0;
        endcase
        s1_next_pc    = s1_taken ? s1_target_q : s1_fall_q;
        // Mask form keeps SHIFT == 0 legal (no alignment bits to test)
        s1_misaligned = s1_taken && (|(s1_target_q & AlignMask));
    end

    // Stage 2 next state: data only changes when a valid S1 entry moves in,
    // so outputs hold steady during a stall and after draining
    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_pc_d      = s2_pc_q;
        s2_target_d  = s2_target_q;
        s2_next_pc_d = s2_next_pc_q;
        s2_taken_d   = s2_taken_q;
        s2_zero_d    = s2_zero_q;
        s2_mis_d     = s2_mis_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_pc_d      = s1_pc_q;
                s2_target_d  = s1_target_q;
                s2_next_pc_d = s1_next_pc;
                s2_taken_d   = s1_taken;
                s2_zero_d    = s1_eq_q;
                s2_mis_d     = s1_misaligned;
            end
        end
    end

    // Saturating statistics; clear wins over a same-cycle delivery
    always_comb begin
        resolved_d = resolved_q;
        taken_d    = taken_q;
        if (cnt_clr) begin
            resolved_d = '0;
            taken_d    = '0;
        end else if (out_hs) begin
            if (resolved_q != CntMax) begin
                resolved_d = resolved_q + CntOne;
            end
            if (s2_taken_q && (taken_q != CntMax)) begin
                taken_d = taken_q + CntOne;
            end
        end
    end

    // Pipeline and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_pc_q      <= '0;
            s1_target_q  <= '0;
            s1_fall_q    <= '0;
            s1_eq_q      <= 1'b0;
            s1_lt_s_q    <= 1'b0;
            s1_lt_u_q    <= 1'b0;
            s1_cond_q    <= CondEq;
            s2_valid_q   <= 1'b0;
            s2_pc_q      <= '0;
            s2_target_q  <= '0;
            s2_next_pc_q <= '0;
            s2_taken_q   <= 1'b0;
            s2_zero_q    <= 1'b0;
            s2_mis_q     <= 1'b0;
            resolved_q   <= '0;
            taken_q      <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_pc_q      <= s1_pc_d;
            s1_target_q  <= s1_target_d;
            s1_fall_q    <= s1_fall_d;
            s1_eq_q      <= s1_eq_d;
            s1_lt_s_q    <= s1_lt_s_d;
            s1_lt_u_q    <= s1_lt_u_d;
            s1_cond_q    <= s1_cond_d;
            s2_valid_q   <= s2_valid_d;
            s2_pc_q      <= s2_pc_d;
            s2_target_q  <= s2_target_d;
            s2_next_pc_q <= s2_next_pc_d;
            s2_taken_q   <= s2_taken_d;
            s2_zero_q    <= s2_zero_d;
            s2_mis_q     <= s2_mis_d;
            resolved_q   <= resolved_d;
            taken_q      <= taken_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        out_valid      = s2_valid_q;
        out_pc         = s2_pc_q;
        out_target     = s2_target_q;
        out_next_pc    = s2_next_pc_q;
        out_taken      = s2_taken_q;
        out_zero       = s2_zero_q;
        out_misaligned = s2_mis_q;
        resolved_cnt   = resolved_q;
        taken_cnt      = taken_q;
    end

endmodule
